// File: rtl/riscv_divider_if.sv
// riscv_divider_if: launch/result bundle between the execute-stage control
// unit (master) and the iterative RV32M divider (slave).
// Optional signal div_zero exists only when RISCV_DIV_ZERO_FLAG_EN is defined.
interface riscv_divider_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            valid;
  logic [XLEN-1:0] result;
`ifdef RISCV_DIV_ZERO_FLAG_EN
  logic            div_zero;
`endif

  modport master (
    output start, flush, op, a, b,
`ifdef RISCV_DIV_ZERO_FLAG_EN
    input  div_zero,
`endif
    input  busy, valid, result
  );

  modport slave (
    input  start, flush, op, a, b,
`ifdef RISCV_DIV_ZERO_FLAG_EN
    output div_zero,
`endif
    output busy, valid, result
  );
endinterface

// File: rtl/riscv_divider.sv
// riscv_divider: iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per clock (32 CALC cycles), with divide-by-zero and
// signed-overflow short-cuts that complete in a single cycle.
// Optional feature: define RISCV_DIV_ZERO_FLAG_EN to add the div_zero output.
module riscv_divider #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  riscv_divider_if.slave    div_if
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_e;

  localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO      = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Two's-complement negate when en is set, pass-through otherwise.
  function automatic logic [XLEN-1:0] neg_cond(input logic [XLEN-1:0] v, input logic en);
    neg_cond = en ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  state_e            state_q,   state_d;
  logic              op_rem_q,  op_rem_d;   // 1: remainder requested
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   divisor_q, divisor_d;
  logic [XLEN-1:0]   quo_q,     quo_d;      // dividend shifts out as quotient shifts in
  logic [XLEN-1:0]   rem_q,     rem_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [XLEN-1:0]   result_q,  result_d;
  logic              valid_q,   valid_d;
  logic              busy_q,    busy_d;
`ifdef RISCV_DIV_ZERO_FLAG_EN
  logic              dz_q,      dz_d;
`endif

  logic              signed_op_s;
  logic [XLEN-1:0]   abs_a_s;
  logic [XLEN-1:0]   abs_b_s;
  logic [XLEN:0]     rem_sh_s;
  logic [XLEN:0]     trial_s;
  logic [XLEN-1:0]   quo_step_s;
  logic [XLEN-1:0]   rem_step_s;

  // Operand decode and one restoring-subtract step of the iteration.
  always_comb begin
    signed_op_s = ~div_if.op[0];
    abs_a_s     = neg_cond(div_if.a, signed_op_s & div_if.a[XLEN-1]);
    abs_b_s     = neg_cond(div_if.b, signed_op_s & div_if.b[XLEN-1]);
    rem_sh_s    = {rem_q, quo_q[XLEN-1]};
    trial_s     = rem_sh_s - {1'b0, divisor_q};
    quo_step_s  = {quo_q[XLEN-2:0], ~trial_s[XLEN]};
    // A negative trial is undone by adding the divisor back (restoring step);
    // the low XLEN bits then equal the shifted partial remainder.
    rem_step_s  = trial_s[XLEN-1:0] + (trial_s[XLEN] ? divisor_q : ZERO);
  end

  // Next-state and datapath-update logic for the IDLE/CALC/DONE sequencer.
  always_comb begin
    state_d   = state_q;
    op_rem_d  = op_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    divisor_d = divisor_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    valid_d   = 1'b0;
`ifdef RISCV_DIV_ZERO_FLAG_EN
    dz_d      = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (div_if.start && !div_if.flush) begin
          op_rem_d  = div_if.op[1];
          neg_quo_d = signed_op_s & (div_if.a[XLEN-1] ^ div_if.b[XLEN-1]);
          neg_rem_d = signed_op_s & div_if.a[XLEN-1];
          divisor_d = abs_b_s;
          quo_d     = abs_a_s;
          rem_d     = ZERO;
          cnt_d     = {CNT_W{1'b0}};
          if (div_if.b == ZERO) begin
            state_d  = S_DONE;
            result_d = div_if.op[1] ? div_if.a : ALL_ONES;
            valid_d  = 1'b1;
`ifdef RISCV_DIV_ZERO_FLAG_EN
            dz_d     = 1'b1;
`endif
          end else if (signed_op_s && (div_if.a == MIN_NEG) && (div_if.b == ALL_ONES)) begin
            state_d  = S_DONE;
            result_d = div_if.op[1] ? ZERO : MIN_NEG;
            valid_d  = 1'b1;
          end else begin
            state_d  = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CALC: begin
        if (div_if.flush) begin
          state_d = S_IDLE;
        end else begin
          quo_d = quo_step_s;
          rem_d = rem_step_s;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == LAST_CNT) begin
            state_d  = S_DONE;
            result_d = op_rem_q ? neg_cond(rem_step_s, neg_rem_q)
                                : neg_cond(quo_step_s, neg_quo_q);
            valid_d  = 1'b1;
          end else begin
            state_d = S_CALC;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers; reset aborts any operation at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divisor_q <= ZERO;
      quo_q     <= ZERO;
      rem_q     <= ZERO;
      cnt_q     <= {CNT_W{1'b0}};
      result_q  <= ZERO;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef RISCV_DIV_ZERO_FLAG_EN
      dz_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_rem_q  <= op_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      divisor_q <= divisor_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
`ifdef RISCV_DIV_ZERO_FLAG_EN
      dz_q      <= dz_d;
`endif
    end
  end

  // A flush arriving in the DONE cycle suppresses that cycle's strobe.
  assign div_if.busy     = busy_q;
  assign div_if.valid    = valid_q & ~div_if.flush;
  assign div_if.result   = result_q;
`ifdef RISCV_DIV_ZERO_FLAG_EN
  assign div_if.div_zero = dz_q & ~div_if.flush;
`endif

endmodule

// File: tb/tb_riscv_divider.sv
// tb_riscv_divider: directed vectors with a result scoreboard. Stimulus pushes
// expected result/latency into queues; a negedge monitor pops on every valid.
module tb_riscv_divider;
  localparam int XLEN = 32;
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  riscv_divider_if #(.XLEN(XLEN)) dif ();
  riscv_divider #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .div_if(dif));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] exp_res_q[$];
  int          exp_start_q[$];
  int          exp_lat_q[$];
  logic        exp_dz_q[$];

  logic [31:0] mon_res;
  int          mon_start;
  int          mon_lat;
  logic        mon_dz;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every valid must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && dif.valid === 1'b1) begin
      if (exp_res_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual=%h required=no_valid", dif.result);
      end else begin
        mon_res   = exp_res_q.pop_front();
        mon_start = exp_start_q.pop_front();
        mon_lat   = exp_lat_q.pop_front();
        mon_dz    = exp_dz_q.pop_front();
        chk("result", dif.result, mon_res);
        chk("latency", 32'(cyc - mon_start), 32'(mon_lat));
`ifdef RISCV_DIV_ZERO_FLAG_EN
        chk("div_zero", {31'd0, dif.div_zero}, {31'd0, mon_dz});
`else
        if (mon_dz === 1'bx) $display("note: unknown div_zero expectation");
`endif
      end
    end
  end

  // Drive a start for one cycle from the current negedge; optionally log expectation.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int lat, input logic dz, input bit push);
    dif.start = 1'b1;
    dif.op    = op;
    dif.a     = a;
    dif.b     = b;
    if (push) begin
      exp_res_q.push_back(exp_res);
      exp_start_q.push_back(cyc + 1);
      exp_lat_q.push_back(lat);
      exp_dz_q.push_back(dz);
    end
    @(negedge clk);
    dif.start = 1'b0;
    dif.a     = 32'hDEAD_BEEF;   // operands must not be re-sampled
    dif.b     = 32'h0000_0000;
    dif.op    = ~op;
  endtask

  // Count busy cycles until idle, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (dif.busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout actual=%0d required=<100", n);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int lat, input logic dz);
    int n;
    issue(op, a, b, exp_res, lat, dz, 1'b1);
    wait_idle(n);
    chk("busy_cycles", 32'(n), 32'(lat + 1));
  endtask

  initial begin
    int n;
    dif.start = 1'b0;
    dif.flush = 1'b0;
    dif.op    = 2'b00;
    dif.a     = 32'd0;
    dif.b     = 32'd0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy",   {31'd0, dif.busy},  32'd0);
    chk("reset_valid",  {31'd0, dif.valid}, 32'd0);
    chk("reset_result", dif.result,          32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(OP_DIVU, 32'd100,        32'd7,          32'd14,         32, 1'b0);
    run_op(OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32, 1'b0);
    run_op(OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32, 1'b0);
    run_op(OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  0,  1'b1);
    run_op(OP_REMU, 32'd5,          32'd0,          32'd5,          0,  1'b1);
    run_op(OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0,  1'b0);
    run_op(OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          0,  1'b0);
    run_op(OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32, 1'b0);
    run_op(OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32, 1'b0);
    run_op(OP_REMU, 32'hFFFF_FFFF,  32'h8000_0000,  32'h7FFF_FFFF,  32, 1'b0);
    run_op(OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32, 1'b0);
    run_op(OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32, 1'b0);
    run_op(OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          32, 1'b0);
    run_op(OP_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  0,  1'b1);
    run_op(OP_DIVU, 32'd100,        32'd7,          32'd14,         32, 1'b0);

    // Flush at CALC step 10: no valid, result keeps 14.
    issue(OP_DIVU, 32'd1000, 32'd3, 32'd0, 0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    dif.flush = 1'b1;
    @(negedge clk);
    dif.flush = 1'b0;
    chk("flush_busy",   {31'd0, dif.busy},  32'd0);
    chk("flush_valid",  {31'd0, dif.valid}, 32'd0);
    chk("flush_result", dif.result,          32'd14);
    run_op(OP_DIVU, 32'd9, 32'd3, 32'd3, 32, 1'b0);

    // Second start while busy is ignored: exactly one valid, first op's result.
    issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 32, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    issue(OP_DIVU, 32'd50, 32'd5, 32'd0, 0, 1'b0, 1'b0);
    wait_idle(n);
    repeat (40) @(negedge clk);
    chk("busy_start_drained", 32'(exp_res_q.size()), 32'd0);

    // Asynchronous reset mid-CALC.
    issue(OP_DIVU, 32'd1000, 32'd3, 32'd0, 0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_busy",   {31'd0, dif.busy},  32'd0);
    chk("midreset_valid",  {31'd0, dif.valid}, 32'd0);
    chk("midreset_result", dif.result,          32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(OP_DIVU, 32'd1000, 32'd3, 32'd333, 32, 1'b0);
    run_op(OP_REMU, 32'd1000, 32'd3, 32'd1,   32, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_res_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
